// File: rtl/sar_avg_pkg.sv
// Shared constants for the SAR sample averager: default code width,
// accumulator width helper and FSM state encoding.
package sar_avg_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_PUSH  = 1'b1;

  function automatic int unsigned acc_w(input int unsigned d, input int unsigned l);
    return d + l;
  endfunction

endpackage

// File: rtl/sar_avg_fifo.sv
// Synchronous first-word-fall-through FIFO for window averages.
// A push on full succeeds when a pop happens in the same cycle.
module sar_avg_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    level   = count;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sar_sample_averager.sv
// Boxcar averager over 2^LOG2_N SAR codes with a result FIFO.
// Define SAR_AVG_MINMAX_EN to add per-window win_min/win_max ports.
module sar_sample_averager
  import sar_avg_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned LOG2_N     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  input  logic                          clear,
  output logic [DATA_W-1:0]             avg_out,
  output logic                          avg_valid,
  input  logic                          avg_ready,
  output logic                          overflow,
`ifdef SAR_AVG_MINMAX_EN
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [DATA_W-1:0]             win_min,
  output logic [DATA_W-1:0]             win_max
`else
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
`endif
);

  localparam int unsigned ACC_W = acc_w(DATA_W, LOG2_N);
  localparam int unsigned CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  logic [0:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  sum_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] avg_push;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    acc_next  = acc + ACC_W'(sample_in);
    avg_push  = DATA_W'(sum_q >> LOG2_N);
    // A clear in the PUSH cycle aborts the write, so the window is lost.
    push      = (state == ST_PUSH) && !clear;
    avg_valid = !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      cnt      <= '0;
      sum_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && fifo_full && !avg_ready) overflow <= 1'b1;
      if (clear) begin
        state <= ST_ACCUM;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        // PUSH lasts one cycle but still accepts sample 0 of the next window.
        state <= ST_ACCUM;
        if (sample_valid) begin
          if (cnt == CNT_LAST) begin
            sum_q <= acc_next;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_PUSH;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  sar_avg_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (avg_push),
    .pop   (avg_ready),
    .dout  (avg_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

`ifdef SAR_AVG_MINMAX_EN
  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_min <= '1;
      run_max <= '0;
      win_min <= '1;
      win_max <= '0;
    end else if (clear) begin
      run_min <= '1;
      run_max <= '0;
    end else if (push) begin
      // Trackers restart with the next window's first sample if it lands now.
      win_min <= run_min;
      win_max <= run_max;
      run_min <= sample_valid ? sample_in : '1;
      run_max <= sample_valid ? sample_in : '0;
    end else if (sample_valid) begin
      if (sample_in < run_min) run_min <= sample_in;
      if (sample_in > run_max) run_max <= sample_in;
    end
  end
`endif

endmodule

// File: doc/sar_sample_averager.md
# sar_sample_averager

Downstream post-processing stage for the 16-bit SAR converter. It consumes each completed conversion code from `SAR_ADC` via a one-cycle strobe and accumulates a boxcar window of 2^LOG2_N samples. Each window average is pushed into a small result FIFO and drained by the consumer over a valid/ready handshake. Optional min/max tracking per window supports bench checks against the CORDIC sine stimulus.

## Interface
Parameters:
- `DATA_W`, 16, width of SAR conversion code (unsigned)
- `LOG2_N`, 3, log2 of window length (N = 8); legal range 0..8
- `FIFO_DEPTH`, 4, result FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock domain
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`
- `sample_in`  in  DATA_W  SAR conversion result (`digital_out`)
- `sample_valid`  in  1  one-cycle strobe; `sample_in` valid this cycle
- `clear`  in  1  synchronous flush of the partial window (FIFO kept)
- `avg_out`  out  DATA_W  head-of-FIFO window average
- `avg_valid`  out  1  FIFO non-empty
- `avg_ready`  in  1  consumer accepts `avg_out` when `avg_valid`&&`avg_ready`
- `overflow`  out  1  sticky; a window result was dropped on full FIFO
- `fill_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `win_min`, `win_max`  out  DATA_W  present only with `SAR_AVG_MINMAX_EN`

## Operation
- Accumulator `acc` is DATA_W+LOG2_N bits, unsigned; cannot overflow.
- Sample counter `cnt` is LOG2_N bits (counts 0..N-1).
- FSM, two states:
  - `ACCUM`: on `sample_valid`, `acc += sample_in`, `cnt++`. When `cnt==N-1` and `sample_valid`, latch `acc+sample_in` into `sum_q`, clear `acc`/`cnt`, go to `PUSH`.
  - `PUSH`: one cycle. Write `sum_q >> LOG2_N` (floor, truncation) into the FIFO, then return to `ACCUM`. A `sample_valid` in this cycle is accepted as sample 0 of the next window.
- FIFO full at push: the result is dropped and `overflow` is set. If a pop happens in the same cycle, the push succeeds and no drop occurs.
- Pop: on `avg_valid && avg_ready`, advance the head. Simultaneous push+pop leaves `fill_level` unchanged.
- `clear`: zeroes `acc`, `cnt`, and min/max trackers, and forces `ACCUM`. It aborts a pending `PUSH`, so that result is lost. A `sample_valid` in the same cycle is ignored. FIFO contents and `overflow` are kept.
- `overflow` is cleared only by `reset`.
- LOG2_N=0: every sample goes straight to `PUSH` (pass-through with 2-cycle latency).

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `overflow`=0, `fill_level`=0, `win_min`=all-ones, `win_max`=0, FSM=`ACCUM`, `acc`=0, `cnt`=0.
- Latency: with the N-th strobe at edge t, `PUSH` runs in cycle t..t+1 and the FIFO write happens at edge t+1. `avg_valid` rises after edge t+1 if the FIFO was empty. That is 2 edges from the last sample to visible output.
- `avg_out` is first-word-fall-through and holds stable while `avg_valid && !avg_ready`.
- Throughput: one sample per cycle sustained; one window result per N cycles.
- `reset` mid-window or mid-`PUSH`: all state returns to reset values at that edge. No output is produced for the partial window.

## Configuration
- `SAR_AVG_MINMAX_EN` defined: adds ports `win_min`/`win_max`.
  - Running min/max are tracked over the current window.
  - On the FIFO write edge, the window extremes are registered to the ports and the trackers reset to all-ones/0.
  - Values update even if the average is dropped on overflow.
- Undefined: ports, trackers and their logic are absent; all other behaviour is identical.

## Structure
- Package `sar_avg_pkg`: `DATA_W` default, `ACC_W(d,l)=d+l` helper constant, FSM state encoding (`ST_ACCUM`=1'b0, `ST_PUSH`=1'b1).
- One sub-module: `sar_avg_fifo`, a synchronous FWFT FIFO with parameters `WIDTH` and `DEPTH`. Its ports are push/pop/full/empty/level. It owns the simultaneous push-on-full-with-pop rule.

## Test plan
- Averaging: LOG2_N=3, strobes every 3 cycles with samples 100..107, `avg_ready`=1 -> one result 103 (sum 828, floor); `avg_valid` high 2 edges after the 8th strobe.
- Width: eight samples of 0xFFFF back-to-back every cycle -> `avg_out`=0xFFFF, no wrap; next window of eight 0x0000 -> 0x0000.
- Backpressure: `avg_ready`=0, five full windows of constant 500, FIFO_DEPTH=4 -> `fill_level`=4, `overflow`=1, then draining yields exactly four 500s; a fifth push coincident with a pop is not dropped.
- Clear: 3 samples of 9000, then `clear`, then eight samples of 50 -> single result 50, no 9000 contribution.
- Reset mid-operation: 5 samples accepted, then `reset` for 1 cycle -> all outputs at reset values; the next 8 samples of 1234 give 1234.
- With `SAR_AVG_MINMAX_EN`: window {10,300,7,55,7,90,299,12} -> `win_min`=7, `win_max`=300, avg=97.
